// File: rtl/read_data_queue.sv
// Read-response queue between a slow-ticked consumer and a memory port, with flush and overflow detection.
// Optional same-cycle bypass of an empty queue is enabled by defining READ_DATA_BYPASS_EN.
module read_data_queue #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_tick,
  input  logic                         io_in_rd,
  input  logic [ADDR_WIDTH-1:0]        io_in_addr,
  output logic [DATA_WIDTH-1:0]        io_in_dout,
  output logic                         io_in_valid,
  output logic                         io_out_rd,
  output logic [ADDR_WIDTH-1:0]        io_out_addr,
  input  logic [DATA_WIDTH-1:0]        io_out_dout,
  input  logic                         io_out_wait_n,
  input  logic                         io_out_valid,
  input  logic                         io_flush,
  output logic [$clog2(DEPTH+1)-1:0]   io_count,
  output logic                         io_overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_S = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, outstanding, drop_cnt;
  logic                  issued, overflow;

  logic [CW:0] inflight;
  logic        accept, empty, full, resp, bypass, pop, push, ovf_set, dec;

  always_comb begin
    inflight  = {1'b0, outstanding} + {1'b0, count};
    io_out_rd = reset & io_in_rd & ~issued & ~io_flush & (inflight < DEPTH_S);
    accept    = io_out_rd & io_out_wait_n;
    empty     = (count == '0);
    full      = (count == DEPTH_C);
    // A response counts only when it is not being thrown away by a flush or the drop counter.
    resp      = io_out_valid & ~io_flush & (drop_cnt == '0);
`ifdef READ_DATA_BYPASS_EN
    bypass    = reset & resp & empty;
`else
    bypass    = 1'b0;
`endif
    pop       = io_tick & ~empty & ~io_flush;
    push      = resp & ~(bypass & io_tick) & (~full | pop);
    ovf_set   = resp & full & ~pop;
    dec       = resp & (outstanding != '0);
  end

  assign io_out_addr = io_in_addr;
  assign io_count    = count;
  assign io_overflow = overflow;
  assign io_in_valid = ~empty | bypass;
  assign io_in_dout  = !empty ? mem[rd_ptr] : (bypass ? io_out_dout : '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      issued      <= 1'b0;
      overflow    <= 1'b0;
    end else if (io_flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      issued      <= 1'b0;
      // Every read still in flight must be swallowed; a response arriving now is already gone.
      drop_cnt    <= (io_out_valid && outstanding != '0) ? outstanding - 1'b1 : outstanding;
    end else begin
      wr_ptr      <= wr_ptr + PW'(push);
      rd_ptr      <= rd_ptr + PW'(pop);
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(accept) - CW'(dec);
      drop_cnt    <= drop_cnt - CW'(io_out_valid & (drop_cnt != '0));
      issued      <= accept | (issued & ~io_tick);
      overflow    <= overflow | ovf_set;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= io_out_dout;
  end

endmodule

// File: doc/read_data_queue.md
READ_DATA_QUEUE -- requirements
Module: read_data_queue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, read data width.
REQ-003 SHALL have parameter DEPTH, default 4, response queue entries and outstanding-read limit; power of two, >=2.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port io_tick  in  1  one-cycle consumer sample strobe (slow-domain clock enable).
REQ-007 SHALL have ports io_in_rd in 1, io_in_addr in ADDR_WIDTH: consumer read request and address.
REQ-008 SHALL have ports io_in_dout out DATA_WIDTH, io_in_valid out 1: held response to consumer.
REQ-009 SHALL have ports io_out_rd out 1, io_out_addr out ADDR_WIDTH: request to memory.
REQ-010 SHALL have ports io_out_dout in DATA_WIDTH, io_out_wait_n in 1 (1 = request accepted), io_out_valid in 1 (response strobe).
REQ-011 SHALL have port io_flush  in  1  synchronous discard of queued and in-flight responses.
REQ-012 SHALL have ports io_count out clog2(DEPTH+1) (queue occupancy) and io_overflow out 1 (sticky protocol error).

Function
REQ-013 io_out_addr SHALL equal io_in_addr combinationally.
REQ-014 io_out_rd SHALL = io_in_rd & ~issued & ~io_flush & (outstanding + io_count < DEPTH).
REQ-015 Accept = io_out_rd & io_out_wait_n; accept SHALL set issued and increment outstanding.
REQ-016 issued SHALL clear on every io_tick cycle: at most one accepted request per tick period.
REQ-017 outstanding SHALL decrement on io_out_valid; accept and io_out_valid same cycle SHALL leave it unchanged.
REQ-018 Responses SHALL be queued in arrival order; the head SHALL drive io_in_dout and stay frozen until popped.
REQ-019 io_in_valid SHALL be 1 when io_count > 0; io_in_dout SHALL be 0 when empty (bypass excepted, REQ-030).
REQ-020 Pop SHALL occur on io_tick & io_in_valid; push on io_out_valid unless discarded or bypass-consumed.
REQ-021 Simultaneous push and pop SHALL leave io_count unchanged; pointers wrap modulo DEPTH.
REQ-022 Queued response latency SHALL be one cycle: io_out_valid in cycle N -> io_in_valid in N+1.
REQ-023 io_out_valid with io_count = DEPTH and no pop SHALL drop the data and set io_overflow (sticky until reset).
REQ-024 io_flush SHALL empty the queue, clear issued, load drop counter with outstanding (minus any same-cycle response), zero outstanding.
REQ-025 While drop counter > 0, each io_out_valid SHALL be discarded and decrement it; no push, no overflow.
REQ-026 io_flush with io_tick same cycle: flush wins, no pop data delivered.

Reset
REQ-027 reset=0 SHALL asynchronously clear pointers, io_count, outstanding, issued, drop counter, io_overflow.
REQ-028 During reset io_out_rd, io_in_valid SHALL be 0 and io_in_dout 0; queue storage need not clear.
REQ-029 Deassertion SHALL be usable synchronously; first accept possible on first clock edge after release.

Configuration
REQ-030 Macro READ_DATA_BYPASS_EN defined: when queue empty and drop counter 0, io_out_valid SHALL drive io_in_valid=1 and io_in_dout=io_out_dout same cycle; if io_tick also 1 the word SHALL be consumed and not queued, else it is pushed.
REQ-031 Macro undefined: no combinational path io_out_* -> io_in_*; all responses pass through the queue (REQ-022).

Verification
REQ-032 Reset release, io_in_rd=1 addr 0x00010, wait_n=1 -> io_out_rd=1 one cycle, outstanding=1, io_out_rd=0 until next io_tick.
REQ-033 Response 0xBEEF, io_tick every 4 cycles -> io_in_dout=0xBEEF, io_in_valid=1 held until tick; then io_count=0.
REQ-034 DEPTH=4, 4 accepted reads, no ticks -> io_out_rd held 0; 4 responses -> io_count=4, order preserved, io_overflow=0.
REQ-035 Unsolicited fifth io_out_valid 0x1234 while full -> io_overflow=1, head unchanged, 0x1234 never appears.
REQ-036 2 outstanding, io_flush -> io_count=0; next two responses discarded; third request's 0x5A5A delivered.
REQ-037 With READ_DATA_BYPASS_EN, empty queue, io_out_valid 0xCAFE plus io_tick -> io_in_valid=1/0xCAFE that cycle, io_count stays 0; without macro, valid appears next cycle.
